// File: rtl/rx_pkg.sv
// Shared definitions for the receive-path routing blocks: FSM states,
// statistics counter width and small elaboration/datapath helpers.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  localparam int CNT_W = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_skid_tag.sv
// Two-entry AXI-Stream skid buffer carrying data, last and a destination tag.
// The input ready is a registered "not full", so it never follows out_ready combinationally.
module axis_skid_tag
  import rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int DEPTH = 2;
  localparam int CW    = clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ready_q;
  logic          push;
  logic          pop;

  assign in_ready  = ready_q;
  assign out_valid = (count != '0);
  assign push      = in_valid && ready_q;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr].data;
  assign out_last  = mem[rd_ptr].last;
  assign out_tag   = mem[rd_ptr].tag;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{tag: in_tag, last: in_last, data: in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count   <= count_next;
      ready_q <= (count_next != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/rx_route_demux.sv
// Route-descriptor driven packet demultiplexer with a tagged skid output stage.
// Define RX_DEMUX_STATS_EN to build the per-destination and drop counters.
module rx_route_demux
  import rx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DEST = 3,
  parameter int DEST_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  input  logic                       route_tvalid,
  output logic                       route_tready,
  input  logic [DEST_W-1:0]          route_tdata,
  output logic [NUM_DEST-1:0]        m_tvalid,
  input  logic [NUM_DEST-1:0]        m_tready,
  output logic [NUM_DEST*DATA_W-1:0] m_tdata,
  output logic [NUM_DEST-1:0]        m_tlast,
  output logic                       drop_pulse,
  output logic                       busy,
  output logic [NUM_DEST*CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]           stat_drop_cnt
);

  localparam logic [31:0] NUM_DEST_U = NUM_DEST;

  rx_state_t         state;
  rx_state_t         state_next;
  logic [DEST_W-1:0] dest_q;
  logic [DEST_W-1:0] dest_next;
  logic              last_hs;
  logic              skid_in_valid;
  logic              skid_in_ready;
  logic              skid_valid;
  logic              skid_ready;
  logic [DATA_W-1:0] skid_data;
  logic              skid_last;
  logic [DEST_W-1:0] skid_tag;

  assign last_hs = s_tvalid && s_tready && s_tlast;
  assign busy    = (state != IDLE) || skid_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dest_q     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      dest_q     <= dest_next;
      drop_pulse <= (state == DROP) && last_hs;
    end
  end

  // A new route may be taken on the closing beat of the current packet, which removes the idle bubble.
  always_comb begin
    state_next = state;
    dest_next  = dest_q;
    if (route_tvalid && route_tready) begin
      dest_next  = route_tdata;
      state_next = ({{(32-DEST_W){1'b0}}, route_tdata} < NUM_DEST_U) ? FWD : DROP;
    end else if (last_hs) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    s_tready      = 1'b0;
    skid_in_valid = 1'b0;
    case (state)
      FWD: begin
        s_tready      = skid_in_ready;
        skid_in_valid = s_tvalid;
      end
      DROP:    s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
    route_tready = rst && ((state == IDLE) || last_hs);
  end

  axis_skid_tag #(
    .DATA_W(DATA_W),
    .TAG_W (DEST_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  (s_tdata),
    .in_last  (s_tlast),
    .in_tag   (dest_q),
    .out_valid(skid_valid),
    .out_ready(skid_ready),
    .out_data (skid_data),
    .out_last (skid_last),
    .out_tag  (skid_tag)
  );

  // Only the destination named by the head tag sees the beat; the rest read zero.
  always_comb begin
    m_tvalid   = '0;
    m_tdata    = '0;
    m_tlast    = '0;
    skid_ready = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (skid_valid && (skid_tag == DEST_W'(i))) begin
        m_tvalid[i]                  = 1'b1;
        m_tdata[i*DATA_W +: DATA_W]  = skid_data;
        m_tlast[i]                   = skid_last;
        skid_ready                   = m_tready[i];
      end
    end
  end

`ifdef RX_DEMUX_STATS_EN
  logic [CNT_W-1:0] pkt_cnt [NUM_DEST];
  logic [CNT_W-1:0] drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        pkt_cnt[i] <= '0;
      end
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (m_tvalid[i] && m_tready[i] && m_tlast[i]) begin
          pkt_cnt[i] <= sat_inc(pkt_cnt[i]);
        end
      end
      if ((state == DROP) && last_hs) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      stat_pkt_cnt[i*CNT_W +: CNT_W] = pkt_cnt[i];
    end
  end
  assign stat_drop_cnt = drop_cnt;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_route_demux.sv
// Self-checking bench for rx_route_demux: a queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_rx_route_demux;

  localparam int DATA_W   = 32;
  localparam int NUM_DEST = 3;
  localparam int DEST_W   = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       s_tvalid;
  logic                       s_tready;
  logic [DATA_W-1:0]          s_tdata;
  logic                       s_tlast;
  logic                       route_tvalid;
  logic                       route_tready;
  logic [DEST_W-1:0]          route_tdata;
  logic [NUM_DEST-1:0]        m_tvalid;
  logic [NUM_DEST-1:0]        m_tready;
  logic [NUM_DEST*DATA_W-1:0] m_tdata;
  logic [NUM_DEST-1:0]        m_tlast;
  logic                       drop_pulse;
  logic                       busy;
  logic [NUM_DEST*16-1:0]     stat_pkt_cnt;
  logic [15:0]                stat_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_route_demux #(
    .DATA_W  (DATA_W),
    .NUM_DEST(NUM_DEST),
    .DEST_W  (DEST_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .route_tvalid (route_tvalid),
    .route_tready (route_tready),
    .route_tdata  (route_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .drop_pulse   (drop_pulse),
    .busy         (busy),
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFOs: the bench feeds beats and routes, holding each until it is accepted
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             s_q[$];
  logic [DEST_W-1:0] r_q[$];
  bit                s_took;
  bit                r_took;

  initial begin : s_driver
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      s_took = rst && s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (rst && s_took && s_q.size() > 0) void'(s_q.pop_front());
      if (rst && s_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = s_q[0].data;
        s_tlast  = s_q[0].last;
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
      end
    end
  end

  initial begin : r_driver
    route_tvalid = 1'b0;
    route_tdata  = '0;
    forever begin
      @(negedge clk);
      r_took = rst && route_tvalid && route_tready;
      @(posedge clk);
      #1;
      if (rst && r_took && r_q.size() > 0) void'(r_q.pop_front());
      if (rst && r_q.size() > 0) begin
        route_tvalid = 1'b1;
        route_tdata  = r_q[0];
      end else begin
        route_tvalid = 1'b0;
        route_tdata  = '0;
      end
    end
  end

  // Reference model: one ordered queue of accepted-but-undelivered beats plus the held route
  typedef struct {
    int                dest;
    logic [DATA_W-1:0] data;
    logic              last;
  } obeat_t;

  obeat_t mq[$];
  bit     have_route;
  int     cur_dest;
  bit     cur_drop;
  bit     drop_due;
  int     exp_pkt[NUM_DEST];
  int     exp_drop;
  int     cycle = 0;

  int     out_dest[$];
  int     out_data[$];
  bit     out_last[$];
  int     out_cyc[$];
  int     s_cyc[$];
  int     r_cyc[$];
  int     drop_seen;
  int     stall_acc;

  bit                exp_s_ready;
  bit                exp_last_hs;
  bit                exp_route_ready;
  logic [NUM_DEST-1:0] exp_mv;
  logic [DATA_W-1:0] exp_d;
  logic              exp_l;

  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      mq.delete();
      have_route = 1'b0;
      cur_drop   = 1'b0;
      drop_due   = 1'b0;
      exp_drop   = 0;
      for (int i = 0; i < NUM_DEST; i++) exp_pkt[i] = 0;
      checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
      checkOutput("rst_route_tready", 64'(route_tready), 64'd0);
      checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_drop_pulse", 64'(drop_pulse), 64'd0);
      checkOutput("rst_stat_pkt", 64'(stat_pkt_cnt), 64'd0);
      checkOutput("rst_stat_drop", 64'(stat_drop_cnt), 64'd0);
    end else begin
      exp_s_ready     = !have_route ? 1'b0 : (cur_drop ? 1'b1 : (mq.size() < 2));
      exp_last_hs     = s_tvalid && exp_s_ready && s_tlast;
      exp_route_ready = !have_route || exp_last_hs;
      exp_mv          = (mq.size() > 0) ? NUM_DEST'(1 << mq[0].dest) : '0;

      checkOutput("s_tready", 64'(s_tready), 64'(exp_s_ready));
      checkOutput("route_tready", 64'(route_tready), 64'(exp_route_ready));
      checkOutput("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
      for (int i = 0; i < NUM_DEST; i++) begin
        exp_d = (mq.size() > 0 && mq[0].dest == i) ? mq[0].data : '0;
        exp_l = (mq.size() > 0 && mq[0].dest == i) ? mq[0].last : 1'b0;
        checkOutput($sformatf("m_tdata[%0d]", i), 64'(m_tdata[i*DATA_W +: DATA_W]), 64'(exp_d));
        checkOutput($sformatf("m_tlast[%0d]", i), 64'(m_tlast[i]), 64'(exp_l));
      end
      checkOutput("busy", 64'(busy), 64'(have_route || mq.size() > 0));
      checkOutput("drop_pulse", 64'(drop_pulse), 64'(drop_due));
`ifdef RX_DEMUX_STATS_EN
      for (int i = 0; i < NUM_DEST; i++)
        checkOutput($sformatf("stat_pkt_cnt[%0d]", i), 64'(stat_pkt_cnt[i*16 +: 16]), 64'(exp_pkt[i]));
      checkOutput("stat_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
`else
      checkOutput("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
      checkOutput("stat_drop_cnt", 64'(stat_drop_cnt), 64'd0);
`endif

      // Observation logs taken from the DUT's own pins for the directed checks
      for (int i = 0; i < NUM_DEST; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          out_dest.push_back(i);
          out_data.push_back(int'(m_tdata[i*DATA_W +: DATA_W]));
          out_last.push_back(m_tlast[i]);
          out_cyc.push_back(cycle);
        end
      end
      if (s_tvalid && s_tready) begin
        s_cyc.push_back(cycle);
        if (!m_tready[2]) stall_acc++;
      end
      if (route_tvalid && route_tready) r_cyc.push_back(cycle);
      if (drop_pulse) drop_seen++;

      // Advance the model across the coming clock edge
      if (mq.size() > 0 && m_tready[mq[0].dest]) begin
        if (mq[0].last && exp_pkt[mq[0].dest] < 16'hFFFF) exp_pkt[mq[0].dest]++;
        void'(mq.pop_front());
      end
      drop_due = 1'b0;
      if (s_tvalid && exp_s_ready) begin
        if (!cur_drop) mq.push_back('{dest: cur_dest, data: s_tdata, last: s_tlast});
        else if (s_tlast) begin
          drop_due = 1'b1;
          if (exp_drop < 16'hFFFF) exp_drop++;
        end
      end
      if (route_tvalid && exp_route_ready) begin
        have_route = 1'b1;
        cur_dest   = int'(route_tdata);
        cur_drop   = (int'(route_tdata) >= NUM_DEST);
      end else if (exp_last_hs) begin
        have_route = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearLogs();
    out_dest.delete();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    s_cyc.delete();
    r_cyc.delete();
    drop_seen = 0;
    stall_acc = 0;
  endtask

  task automatic applyStimulus(input int dest, input int base, input int n, input bit with_route);
    if (with_route) r_q.push_back(DEST_W'(dest));
    for (int k = 0; k < n; k++) s_q.push_back('{data: DATA_W'(base + k), last: (k == n - 1)});
  endtask

  task automatic waitDrain(input string name, input int budget);
    int c;
    c = 0;
    while (!(s_q.size() == 0 && r_q.size() == 0 && !s_tvalid && !busy && mq.size() == 0) && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput({name, "_drain_timeout"}, 64'(c >= budget), 64'd0);
    tick(2);
  endtask

  task automatic checkPacket(input string name, input int first, input int dest, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (first + k < out_data.size()) begin
        checkOutput($sformatf("%s_dest%0d", name, k), 64'(out_dest[first + k]), 64'(dest));
        checkOutput($sformatf("%s_data%0d", name, k), 64'(out_data[first + k]), 64'(base + k));
        checkOutput($sformatf("%s_last%0d", name, k), 64'(out_last[first + k]), 64'(k == n - 1));
      end else begin
        checkOutput($sformatf("%s_missing%0d", name, k), 64'(out_data.size()), 64'(first + k + 1));
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c;
    m_tready = '1;
    clearLogs();
    tick(3);
    checkOutput("reset_s_tready", 64'(s_tready), 64'd0);
    checkOutput("reset_route_tready", 64'(route_tready), 64'd0);
    checkOutput("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    rst = 1'b1;
    tick(2);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    $display("[TB] basic forward to dest 1");
    clearLogs();
    applyStimulus(1, 'hA0, 4, 1'b1);
    waitDrain("t1", 100);
    checkOutput("t1_count", 64'(out_data.size()), 64'd4);
    checkPacket("t1", 0, 1, 'hA0, 4);
    if (out_cyc.size() > 0 && s_cyc.size() > 0)
      checkOutput("t1_latency", 64'(out_cyc[0] - s_cyc[0]), 64'd1);

    $display("[TB] back-to-back packets to dest 0 and dest 2");
    clearLogs();
    applyStimulus(0, 'hB0, 3, 1'b1);
    applyStimulus(2, 'hC0, 1, 1'b1);
    waitDrain("t2", 100);
    checkOutput("t2_in_count", 64'(s_cyc.size()), 64'd4);
    if (s_cyc.size() == 4) checkOutput("t2_no_gap", 64'(s_cyc[3] - s_cyc[0]), 64'd3);
    checkOutput("t2_out_count", 64'(out_data.size()), 64'd4);
    checkPacket("t2a", 0, 0, 'hB0, 3);
    checkPacket("t2b", 3, 2, 'hC0, 1);

    $display("[TB] backpressure on dest 2");
    clearLogs();
    applyStimulus(2, 'hD0, 8, 1'b1);
    tick(3);
    m_tready = 3'b011;
    tick(5);
    m_tready = 3'b111;
    waitDrain("t3", 100);
    checkOutput("t3_stall_accepts_le2", 64'(stall_acc <= 2), 64'd1);
    checkOutput("t3_count", 64'(out_data.size()), 64'd8);
    checkPacket("t3", 0, 2, 'hD0, 8);

    $display("[TB] invalid route 3 is dropped");
    clearLogs();
    applyStimulus(3, 'hE0, 2, 1'b1);
    waitDrain("t4", 100);
    checkOutput("t4_in_count", 64'(s_cyc.size()), 64'd2);
    checkOutput("t4_out_count", 64'(out_data.size()), 64'd0);
    checkOutput("t4_drop_pulses", 64'(drop_seen), 64'd1);
`ifdef RX_DEMUX_STATS_EN
    checkOutput("t4_stat_drop", 64'(stat_drop_cnt), 64'd1);
    checkOutput("t4_stat_pkt", 64'(stat_pkt_cnt), {16'd0, 16'd0, 16'd2, 16'd1, 16'd1});
`else
    checkOutput("t4_stat_drop", 64'(stat_drop_cnt), 64'd0);
`endif

    $display("[TB] data waiting without a route");
    clearLogs();
    applyStimulus(0, 'hF0, 2, 1'b0);
    tick(10);
    checkOutput("t5_s_tready", 64'(s_tready), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_no_accept", 64'(s_cyc.size()), 64'd0);
    r_q.push_back(DEST_W'(0));
    waitDrain("t5", 100);
    if (s_cyc.size() > 0 && r_cyc.size() > 0)
      checkOutput("t5_start_next_cycle", 64'(s_cyc[0] - r_cyc[0]), 64'd1);
    else
      checkOutput("t5_handshakes", 64'(s_cyc.size() > 0 && r_cyc.size() > 0), 64'd1);
    checkPacket("t5", 0, 0, 'hF0, 2);

    $display("[TB] reset in the middle of a packet");
    clearLogs();
    applyStimulus(1, 'h10, 4, 1'b1);
    c = 0;
    while (s_cyc.size() < 2 && c < 50) begin
      tick(1);
      c++;
    end
    checkOutput("t6_reach_beat2", 64'(c >= 50), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6_async_s_tready", 64'(s_tready), 64'd0);
    checkOutput("t6_async_route_tready", 64'(route_tready), 64'd0);
    checkOutput("t6_async_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("t6_async_m_tdata", 64'(m_tdata[63:0]), 64'd0);
    checkOutput("t6_async_busy", 64'(busy), 64'd0);
    s_q.delete();
    r_q.delete();
    tick(2);
    rst = 1'b1;
    tick(2);
    clearLogs();
    applyStimulus(1, 'h20, 2, 1'b1);
    waitDrain("t6", 100);
    checkOutput("t6_count", 64'(out_data.size()), 64'd2);
    checkPacket("t6", 0, 1, 'h20, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_route_demux.md
Name: rx_route_demux

Overview:
Parametrised packet demultiplexer on the receive path, successor to the fixed three-way rx arbiter. It consumes one route descriptor per packet from a route FIFO and steers the whole AXI-Stream packet from the rx interface FIFO to one of NUM_DEST slot/pass-through outputs. It adds back-to-back packets with no idle bubble, a registered output stage, and discard of packets whose route is invalid.

Parameters:
DATA_W, 32, stream data width in bits
NUM_DEST, 3, number of destination outputs (2..16)
DEST_W, 2, route descriptor width; must satisfy 2**DEST_W >= NUM_DEST

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_tvalid  in  1  rx stream valid
s_tready  out  1  rx stream ready
s_tdata  in  DATA_W  rx stream data
s_tlast  in  1  rx stream end of packet
route_tvalid  in  1  route descriptor valid
route_tready  out  1  route descriptor accept
route_tdata  in  DEST_W  destination index
m_tvalid  out  NUM_DEST  per-destination valid
m_tready  in  NUM_DEST  per-destination ready
m_tdata  out  NUM_DEST*DATA_W  per-destination data; destination i occupies bits [i*DATA_W +: DATA_W]
m_tlast  out  NUM_DEST  per-destination last
drop_pulse  out  1  one-cycle pulse when a dropped packet's last beat is consumed
busy  out  1  high while a packet is being forwarded or dropped
stat_pkt_cnt  out  NUM_DEST*16  per-destination forwarded-packet counters (see Optional Feature)
stat_drop_cnt  out  16  dropped-packet counter (see Optional Feature)

Behaviour:
- Reset: asynchronous assert, synchronous-to-clk deassert handled externally.
- Values during reset: state=IDLE; all outputs 0, including s_tready, route_tready, m_tvalid, drop_pulse and the counters. The output register is emptied.
- States:
  - IDLE: no route held.
  - FWD: forwarding to dest d.
  - DROP: discarding the current packet.
- route_tready = (state==IDLE) OR (last-beat handshake on s_ in FWD/DROP).
- A route handshake latches d = route_tdata.
  - d < NUM_DEST -> FWD.
  - d >= NUM_DEST -> DROP.
- Last-beat handshake with route_tvalid high: the next route is latched in the same cycle, giving zero bubble between packets. With route_tvalid low: return to IDLE.
- FWD:
  - s_tready = output-stage ready for d.
  - Beats enter the output register; only m_tvalid[d] may assert.
  - Data, last and valid reach m_* 1 cycle after the s_ handshake.
- Output stage: 2-entry skid buffer.
  - Sustains 1 beat/cycle.
  - s_tready never depends combinationally on m_tready.
  - Skid buffer outputs a registered "not full".
- DROP:
  - s_tready = 1; beats are discarded.
  - drop_pulse is asserted the cycle after the s_tlast handshake.
- Data before a route: s_ data arriving in IDLE sees s_tready=0 and is held upstream. A route must never be inferred from data.
- Single-beat packet (first beat carries tlast): legal; the FSM goes FWD->IDLE/FWD on that beat.
- Destination change: the skid buffer must drain beats for the old d before m_tvalid for the new d asserts.
  - The skid buffer carries a dest tag.
  - m_tvalid[i] = buf_valid && tag==i.
  - Ordering is preserved.
- Unselected destinations: m_tdata and m_tlast are held at 0.
- busy = state != IDLE OR skid buffer not empty.
- Reset mid-packet: the packet is abandoned. Upstream FIFOs share the reset, so no residual beats are expected.

Optional Feature:
Macro RX_DEMUX_STATS_EN.
- Defined:
  - stat_pkt_cnt[i] increments on each m_ last-beat handshake for dest i.
  - stat_drop_cnt increments per dropped packet.
  - Both are 16-bit and saturate at 0xFFFF; they are cleared only by reset.
- Undefined: counter logic is removed and both stat ports are tied to 0. The port list is unchanged.

Decomposition:
Shared package rx_pkg:
- state encoding localparams (IDLE, FWD, DROP)
- CNT_W = 16
- helper clog2 function

Sub-module axis_skid_tag: 2-entry skid buffer carrying DATA_W data, last, and a DEST_W tag. It is reused later for tx-side muxing.

Test Plan:
1. Basic forward: NUM_DEST=3; route 1; 4-beat packet 0xA0..0xA3, all m_tready=1 -> beats appear only on dest 1, one cycle after each input handshake; tlast on 0xA3.
2. Back-to-back: routes 0,2 queued; packets of 3 and 1 beats, s_tvalid continuous -> 4 consecutive s_ handshakes, no gap; dest 0 gets 3 beats, dest 2 gets 1 beat.
3. Backpressure: dest 2 has m_tready=0 for 5 cycles mid-packet -> at most 2 beats buffered; s_tready low within 1 cycle; no loss or duplication after release.
4. Invalid route: route 3 with NUM_DEST=3; 2-beat packet -> s_tready=1 throughout; all m_tvalid=0; drop_pulse for 1 cycle; stat_drop_cnt=1 with RX_DEMUX_STATS_EN.
5. No route: s_tvalid=1, route_tvalid=0 for 10 cycles -> s_tready=0, busy=0; route 0 arrives -> forwarding starts on the next cycle.
6. Reset mid-packet: rst low during beat 2 of 4 -> all outputs 0 immediately (asynchronous); after release state is IDLE and the next route/packet forwards correctly.
